// File: rtl/smg_pkg.sv
// Shared constants for the seven-segment scan driver: digit-code width and
// the active-low segment patterns, packed as {g,f,e,d,c,b,a}.
package smg_pkg;

   localparam int CODE_W = 4;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/smg_seg_lut.sv
// Digit code to active-low seven-segment pattern; codes 10..15 show as hex
// letters only when hex_en is set, otherwise they come out dark.
module smg_seg_lut
   import smg_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   input  logic              hex_en,
   output logic [6:0]        seg
);

   // NOTE: every output of an always_comb gets a default first so no path
   // through the case can leave it unassigned and infer a latch.
   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'd0:  seg = SEG_0;
         4'd1:  seg = SEG_1;
         4'd2:  seg = SEG_2;
         4'd3:  seg = SEG_3;
         4'd4:  seg = SEG_4;
         4'd5:  seg = SEG_5;
         4'd6:  seg = SEG_6;
         4'd7:  seg = SEG_7;
         4'd8:  seg = SEG_8;
         4'd9:  seg = SEG_9;
         4'd10: seg = hex_en ? SEG_A : SEG_BLANK;
         4'd11: seg = hex_en ? SEG_B : SEG_BLANK;
         4'd12: seg = hex_en ? SEG_C : SEG_BLANK;
         4'd13: seg = hex_en ? SEG_D : SEG_BLANK;
         4'd14: seg = hex_en ? SEG_E : SEG_BLANK;
         4'd15: seg = hex_en ? SEG_F : SEG_BLANK;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/smg_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered display data,
// leading-zero suppression, decimal points and per-digit blanking.
module smg_scan_driver
   import smg_pkg::*;
#(
   parameter int N_DIG          = 6,
   parameter int DIV            = 50000,
   parameter int HEX_EN         = 1,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int SEL_ACTIVE_LOW = 1
) (
   input  logic                    CLK,
   input  logic                    RSTn,
   input  logic [CODE_W*N_DIG-1:0] Number_Data,
   input  logic [N_DIG-1:0]        DP_Mask,
   input  logic [N_DIG-1:0]        Blank_Mask,
   input  logic                    LZ_En,
   input  logic                    Load,
   output logic [7:0]              SMG_Data,
   output logic [N_DIG-1:0]        Scan_Sel,
   output logic                    Frame_Done
);

   localparam int DIV_W = $clog2(DIV);
   localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
   localparam logic             HEX_ON   = (HEX_EN != 0);
   localparam logic [7:0]       SMG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [N_DIG-1:0] SEL_OFF  = (SEL_ACTIVE_LOW != 0) ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

   typedef struct packed {
      logic [N_DIG-1:0][CODE_W-1:0] data;
      logic [N_DIG-1:0]             dp;
      logic [N_DIG-1:0]             blank;
      logic                         lz;
   } frame_buf_t;

   logic [DIV_W-1:0] div_cnt;
   logic [IDX_W-1:0] idx, next_idx;
   logic             tc, frame_end;

   frame_buf_t load_buf, pend_buf, act_buf, next_act;
   logic       pend_flag;

   logic [N_DIG-1:0]  lz_blank;
   logic              zero_run;
   logic [CODE_W-1:0] cur_code;
   logic [6:0]        seg7;
   logic              blanked;
   logic [7:0]        pattern_low, seg_next;
   logic [N_DIG-1:0]  sel_onehot, sel_next;

   assign load_buf = {Number_Data, DP_Mask, Blank_Mask, LZ_En};

   always_comb begin
      tc        = (div_cnt == DIV_LAST);
      frame_end = tc && (idx == IDX_LAST);
      next_idx  = frame_end ? '0 : idx + 1'b1;
   end

   // The buffer the next slot will show: a Load on the boundary cycle wins
   // over older pending data, so digit 0 of the new frame already uses it.
   always_comb begin
      next_act = act_buf;
      if (frame_end) begin
         if (Load)
            next_act = load_buf;
         else if (pend_flag)
            next_act = pend_buf;
      end
   end

   // Zeros are suppressed from the top digit down until the first nonzero;
   // digit 0 is never part of the run.
   always_comb begin
      lz_blank = '0;
      zero_run = next_act.lz;
      for (int k = N_DIG - 1; k >= 1; k--) begin
         zero_run    = zero_run && (next_act.data[k] == '0);
         lz_blank[k] = zero_run;
      end
   end

   assign cur_code = next_act.data[next_idx];

   smg_seg_lut u_seg_lut (
      .code   (cur_code),
      .hex_en (HEX_ON),
      .seg    (seg7)
   );

   always_comb begin
      blanked = next_act.blank[next_idx] || lz_blank[next_idx] ||
                (!HEX_ON && (cur_code > CODE_W'(9)));
      pattern_low = blanked ? 8'hFF : {~next_act.dp[next_idx], seg7};
      seg_next    = (SEG_ACTIVE_LOW != 0) ? pattern_low : ~pattern_low;
      sel_onehot  = N_DIG'(1) << next_idx;
      sel_next    = (SEL_ACTIVE_LOW != 0) ? ~sel_onehot : sel_onehot;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         div_cnt    <= '0;
         idx        <= IDX_LAST;
         SMG_Data   <= SMG_OFF;
         Scan_Sel   <= SEL_OFF;
         Frame_Done <= 1'b0;
      end else begin
         div_cnt    <= tc ? '0 : div_cnt + 1'b1;
         Frame_Done <= frame_end;
         if (tc) begin
            idx      <= next_idx;
            SMG_Data <= seg_next;
            Scan_Sel <= sel_next;
         end
      end
   end

   // NOTE: the display buffers are reset as well because their cleared
   // contents are shown on the first frame after reset.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         act_buf   <= '0;
         pend_buf  <= '0;
         pend_flag <= 1'b0;
      end else begin
         act_buf <= next_act;
         if (frame_end) begin
            pend_flag <= 1'b0;
         end else if (Load) begin
            pend_buf  <= load_buf;
            pend_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_smg_scan_driver.sv
// Directed bench for smg_scan_driver with N_DIG=4, DIV=4; a second instance
// with hex letters disabled shares the same stimulus.
module tb_smg_scan_driver;

   localparam int N_DIG = 4;
   localparam int DIV   = 4;

   logic        CLK;
   logic        RSTn;
   logic [15:0] Number_Data;
   logic [3:0]  DP_Mask;
   logic [3:0]  Blank_Mask;
   logic        LZ_En;
   logic        Load;

   logic [7:0]  smg, smg_nh;
   logic [3:0]  sel, sel_nh;
   logic        fd, fd_nh;

   int checks   = 0;
   int failures = 0;

   smg_scan_driver #(.N_DIG(N_DIG), .DIV(DIV), .HEX_EN(1)) dut (
      .CLK         (CLK),
      .RSTn        (RSTn),
      .Number_Data (Number_Data),
      .DP_Mask     (DP_Mask),
      .Blank_Mask  (Blank_Mask),
      .LZ_En       (LZ_En),
      .Load        (Load),
      .SMG_Data    (smg),
      .Scan_Sel    (sel),
      .Frame_Done  (fd)
   );

   smg_scan_driver #(.N_DIG(N_DIG), .DIV(DIV), .HEX_EN(0)) dut_nohex (
      .CLK         (CLK),
      .RSTn        (RSTn),
      .Number_Data (Number_Data),
      .DP_Mask     (DP_Mask),
      .Blank_Mask  (Blank_Mask),
      .LZ_En       (LZ_En),
      .Load        (Load),
      .SMG_Data    (smg_nh),
      .Scan_Sel    (sel_nh),
      .Frame_Done  (fd_nh)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Called at the first cycle of a frame; checks every slot and ends at the
   // first cycle of the next frame. exp_seg byte d is the digit-d pattern.
   task automatic check_frame(input string tag, input logic [31:0] exp_seg);
      for (int d = 0; d < N_DIG; d++) begin
         check($sformatf("%s_d%0d_seg", tag, d), smg, exp_seg[8*d +: 8]);
         check($sformatf("%s_d%0d_sel", tag, d), sel, 4'hF ^ (4'h1 << d));
         check($sformatf("%s_d%0d_fd", tag, d), fd, (d == 0) ? 1 : 0);
         tick();
         check($sformatf("%s_d%0d_hold", tag, d), smg, exp_seg[8*d +: 8]);
         check($sformatf("%s_d%0d_fd1", tag, d), fd, 0);
         repeat (DIV - 1) tick();
      end
   endtask

   // Called at the first cycle of a frame; loads new data and ends at the
   // first cycle of the following frame, where that data becomes visible.
   task automatic load_next_frame(input logic [15:0] data, input logic [3:0] dp,
                                  input logic [3:0] blank, input logic lz);
      Number_Data = data;
      DP_Mask     = dp;
      Blank_Mask  = blank;
      LZ_En       = lz;
      Load        = 1'b1;
      tick();
      Load = 1'b0;
      repeat (N_DIG * DIV - 1) tick();
   endtask

   initial begin
      RSTn        = 1'b0;
      Number_Data = '0;
      DP_Mask     = '0;
      Blank_Mask  = '0;
      LZ_En       = 1'b0;
      Load        = 1'b0;

      #12;
      check("rst_seg", smg, 8'hFF);
      check("rst_sel", sel, 4'hF);
      check("rst_fd", fd, 0);

      // Load 0x1234 in the very first cycle after release.
      Number_Data = 16'h1234;
      Load        = 1'b1;
      RSTn        = 1'b1;
      tick();
      Load = 1'b0;
      repeat (2) tick();
      check("pre_tc_seg", smg, 8'hFF);
      check("pre_tc_fd", fd, 0);
      tick();
      check_frame("f1234", 32'hF9A4B099);

      // Two loads inside one frame: current frame untouched, last load wins.
      Number_Data = 16'h1111;
      Load        = 1'b1;
      tick();
      Number_Data = 16'h2222;
      tick();
      Load = 1'b0;
      check("mid_d0_seg", smg, 8'h99);
      check("mid_d0_sel", sel, 4'hE);
      repeat (2) tick();
      check("mid_d1_seg", smg, 8'hB0);
      repeat (8) tick();
      check("mid_d3_seg", smg, 8'hF9);
      check("mid_d3_sel", sel, 4'h7);
      repeat (4) tick();
      check_frame("f2222", 32'hA4A4A4A4);

      // Load exactly on the frame-boundary cycle.
      check("pre_bnd_seg", smg, 8'hA4);
      repeat (N_DIG * DIV - 1) tick();
      Number_Data = 16'h5678;
      Load        = 1'b1;
      tick();
      Load = 1'b0;
      check_frame("f5678", 32'h9282F880);

      // Hex letters, decimal point and blanking on digit 0.
      load_next_frame(16'h000A, 4'b0000, 4'b0000, 1'b0);
      check("hexA_on", smg, 8'h88);
      check("hexA_off", smg_nh, 8'hFF);
      check("hexA_sel_off", sel_nh, 4'hE);
      load_next_frame(16'h000A, 4'b0001, 4'b0000, 1'b0);
      check("hexA_dp_on", smg, 8'h08);
      check("hexA_dp_off", smg_nh, 8'hFF);
      load_next_frame(16'h000A, 4'b0001, 4'b0001, 1'b0);
      check("blank_on", smg, 8'hFF);
      check("blank_sel", sel, 4'hE);
      check("blank_off", smg_nh, 8'hFF);

      // Leading-zero suppression.
      load_next_frame(16'h0050, 4'b0000, 4'b0000, 1'b1);
      check_frame("lz0050", 32'hFFFF92C0);
      load_next_frame(16'h0000, 4'b0000, 4'b0000, 1'b1);
      check_frame("lz0000", 32'hFFFFFFC0);

      // Reset mid-slot with pending data outstanding.
      Number_Data = 16'h3333;
      LZ_En       = 1'b0;
      Load        = 1'b1;
      tick();
      Load = 1'b0;
      #2;
      RSTn = 1'b0;
      #1;
      check("mid_rst_seg", smg, 8'hFF);
      check("mid_rst_sel", sel, 4'hF);
      check("mid_rst_fd", fd, 0);
      #2;
      RSTn = 1'b1;
      repeat (DIV) tick();
      check_frame("post_rst", 32'hC0C0C0C0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
